// File: rtl/key_events_pkg.sv
// Shared types and default timing constants for the key event decoder and
// the timer control logic that consumes its events.
package key_events_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } key_state_t;

  localparam int KEY_LONG_CYCLES   = 25_000_000;
  localparam int KEY_REPEAT_CYCLES = 5_000_000;

  // Counter width large enough for the longer of the two hold thresholds.
  function automatic int cnt_width(input int long_c, input int rep_c);
    int m;
    m = (long_c > rep_c) ? long_c : rep_c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_events_if.sv
// Debounced key level in, single-cycle UI events out.
interface key_events_if;
  logic key_press;
  logic pressed;
  logic released;
  logic click;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output key_press,
    input  pressed, released, click, long_press, repeat_pulse, held
  );

  modport slave (
    input  key_press,
    output pressed, released, click, long_press, repeat_pulse, held
  );
endinterface

// File: rtl/key_events_edge.sv
// One-cycle delayed copy of the key level with rising/falling edge strobes.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic rise,
  output logic fall
);

  logic key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= 1'b0;
    else        key_q <= key;
  end

  assign rise = key & ~key_q;
  assign fall = ~key & key_q;

endmodule

// File: rtl/key_events.sv
// Turns a debounced key level into press/release/click/long-press/repeat pulses.
// state | meaning
// IDLE  | key released, waiting for a rising edge
// PRESS | key held, long-press threshold not yet reached
// LONG  | long_press fired, auto-repeating while held
module key_events
  import key_events_pkg::*;
#(
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  key_events_if.slave  kif
);

  localparam int              CNT_W   = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  key_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rise, fall;

  logic pressed_q, released_q, click_q, long_q, rep_q, held_q;
  logic pressed_n, released_n, click_n, long_n, rep_n, held_n;

  key_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (kif.key_press),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pressed_q  <= pressed_n;
      released_q <= released_n;
      click_q    <= click_n;
      long_q     <= long_n;
      rep_q      <= rep_n;
      held_q     <= held_n;
    end
  end

  // While in PRESS/LONG the previous sample is always high, so fall equals !key_press.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESS;
          cnt_n   = '0;
        end
      end
      PRESS: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LONG_TC) begin
          state_n = LONG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (REPEAT_EN && (cnt == REP_TC)) begin
          cnt_n = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    pressed_n  = 1'b0;
    released_n = 1'b0;
    click_n    = 1'b0;
    long_n     = 1'b0;
    rep_n      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          pressed_n = 1'b1;
          rep_n     = 1'b1;
        end
      end
      PRESS: begin
        if (fall) begin
          released_n = 1'b1;
          click_n    = 1'b1;
        end else if (cnt == LONG_TC) begin
          long_n = 1'b1;
          rep_n  = REPEAT_EN;
        end
      end
      LONG: begin
        if (fall)                                released_n = 1'b1;
        else if (REPEAT_EN && (cnt == REP_TC))   rep_n      = 1'b1;
      end
      default: ;
    endcase
    held_n = (state_n != IDLE);
  end

  assign kif.pressed      = pressed_q;
  assign kif.released     = released_q;
  assign kif.click        = click_q;
  assign kif.long_press   = long_q;
  assign kif.repeat_pulse = rep_q;
  assign kif.held         = held_q;

endmodule

// File: tb/tb_key_events.sv
// Directed and randomized key sequences against a hold-time based reference model;
// dut_a auto-repeats, dut_b does not, both see the same key level.
module tb_key_events;

  localparam int L = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic key;

  always #5 clk = ~clk;

  key_events_if kif_a ();
  key_events_if kif_b ();

  assign kif_a.key_press = key;
  assign kif_b.key_press = key;

  key_events #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif_a)
  );

  key_events #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif_b)
  );

  // {pressed, released, click, long_press, repeat_pulse, held}
  wire [5:0] obs_a = {kif_a.pressed, kif_a.released, kif_a.click,
                      kif_a.long_press, kif_a.repeat_pulse, kif_a.held};
  wire [5:0] obs_b = {kif_b.pressed, kif_b.released, kif_b.click,
                      kif_b.long_press, kif_b.repeat_pulse, kif_b.held};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_e counts clock edges since the edge that saw the press.
  bit m_active;
  bit m_prev;
  int m_e;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic k, input string tag);
    bit p, r, c, lp, ra;
    logic [5:0] ea, eb;
    @(negedge clk);
    key = k;
    p = 0; r = 0; c = 0; lp = 0; ra = 0;
    if (!m_active) begin
      if (k && !m_prev) begin
        p = 1; ra = 1;
        m_active = 1;
        m_e = 0;
      end
    end else begin
      m_e++;
      if (!k) begin
        r = 1;
        c = (m_e <= L);
        m_active = 0;
      end else if (m_e == L) begin
        lp = 1; ra = 1;
      end else if (m_e > L && ((m_e - L) % R) == 0) begin
        ra = 1;
      end
    end
    m_prev = k;
    ea = {p, r, c, lp, ra, m_active};
    eb = {p, r, c, lp, p,  m_active};
    @(posedge clk);
    #1;
    chk({tag, "_a"}, obs_a, ea);
    chk({tag, "_b"}, obs_b, eb);
    chk({tag, "_excl"}, {5'b0, obs_a[5] & obs_a[4]}, 6'b0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_a"}, obs_a, 6'b0);
    chk({tag, "_async_b"}, obs_b, 6'b0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_a"}, obs_a, 6'b0);
      chk({tag, "_hold_b"}, obs_b, 6'b0);
    end
    rst_n    = 1'b1;
    m_active = 0;
    m_prev   = 0;
    m_e      = 0;
  endtask

  initial begin
    key      = 1'b0;
    rst_n    = 1'b0;
    m_active = 0;
    m_prev   = 0;
    m_e      = 0;
    #1;
    chk("reset_a", obs_a, 6'b0);
    chk("reset_b", obs_b, 6'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_a", obs_a, 6'b0);
    rst_n = 1'b1;

    repeat (4)  step(1'b1, "click");
    repeat (3)  step(1'b0, "click");

    repeat (21) step(1'b1, "long");
    repeat (3)  step(1'b0, "long");

    repeat (8)  step(1'b1, "race");
    repeat (2)  step(1'b0, "race");

    repeat (30) step(1'b1, "hold30");
    repeat (3)  step(1'b0, "hold30");

    repeat (10) step(1'b1, "rst_mid");
    do_reset(2, "rst_mid");
    repeat (5)  step(1'b1, "rst_mid");
    repeat (2)  step(1'b0, "rst_mid");

    repeat (4) begin
      step(1'b1, "b2b");
      step(1'b0, "b2b");
    end
    step(1'b0, "b2b");

    for (int i = 0; i < 60; i++) begin
      int h, g;
      h = $urandom_range(1, 26);
      g = $urandom_range(1, 4);
      for (int j = 0; j < h; j++) begin
        step(1'b1, "rand");
        if ($urandom_range(0, 99) == 0) do_reset(1, "rand_rst");
      end
      for (int j = 0; j < g; j++) step(1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
